// File: rtl/axi_sram_ctrl.sv
// AXI4 slave front end for a single-port synchronous SRAM.
// The read and write channels share the macro. AW and AR are arbitrated
// round-robin once per burst. FIXED, INCR and WRAP bursts are broken into
// single-word accesses, and the controller generates the B and R responses.
module axi_sram_ctrl #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_AW     = ADDR_WIDTH - $clog2(STRB_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_en,
    output logic [STRB_WIDTH-1:0] mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int         OFFSET   = $clog2(STRB_WIDTH);
    localparam logic [2:0] MAX_SIZE = 3'(OFFSET);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_WRESP    = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_DATA  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state;
    logic                  last_grant_wr;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            cur_len;
    logic [2:0]            cur_size;
    logic [1:0]            cur_burst;
    logic [7:0]            beat_cnt;
    logic                  wlast_err;

    logic                  grant_wr;
    logic                  grant_rd;
    logic                  burst_err;
    logic                  last_beat;
    logic                  w_beat;
    logic                  wrap_len_ok;
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    // When both channels request, the side that was not served last wins.
    assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !last_grant_wr);
    assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || last_grant_wr);

    assign s_axi_awready = (state == ST_IDLE) && grant_wr;
    assign s_axi_arready = (state == ST_IDLE) && grant_rd;

    assign wrap_len_ok = (cur_len == 8'd1) || (cur_len == 8'd3) ||
                         (cur_len == 8'd7) || (cur_len == 8'd15);
    assign burst_err   = (cur_size > MAX_SIZE) || (cur_burst == 2'b11) ||
                         ((cur_burst == 2'b10) && !wrap_len_ok);
    assign last_beat   = (beat_cnt == cur_len);
    assign w_beat      = (state == ST_WRITE) && s_axi_wvalid;

    assign bytes     = ADDR_WIDTH'(1) << cur_size;
    assign wrap_mask = (bytes * (ADDR_WIDTH'(cur_len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);

    // Compute the address of the following beat for the captured burst type.
    always_comb begin
        next_addr = cur_addr;
        case (cur_burst)
            2'b01:   next_addr = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            2'b10:   next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + bytes) & wrap_mask);
            default: next_addr = cur_addr;
        endcase
    end

    assign s_axi_wready = (state == ST_WRITE);

    assign s_axi_bvalid = (state == ST_WRESP);
    assign s_axi_bid    = cur_id;
    assign s_axi_bresp  = (s_axi_bvalid && (burst_err || wlast_err)) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_rvalid = (state == ST_RD_DATA);
    assign s_axi_rid    = cur_id;
    assign s_axi_rdata  = (s_axi_rvalid && !burst_err) ? mem_rdata : '0;
    assign s_axi_rlast  = s_axi_rvalid && last_beat;
    assign s_axi_rresp  = (s_axi_rvalid && burst_err) ? RESP_SLVERR : RESP_OKAY;

    assign mem_en    = w_beat || (state == ST_RD_ISSUE);
    assign mem_we    = (w_beat && !burst_err) ? s_axi_wstrb : '0;
    assign mem_addr  = cur_addr[ADDR_WIDTH-1:OFFSET];
    assign mem_wdata = s_axi_wdata;

    // Main sequencer. It captures the granted request, then steps through
    // the burst one word per beat and returns to IDLE after the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant_wr <= 1'b0;
            cur_id        <= '0;
            cur_addr      <= '0;
            cur_len       <= '0;
            cur_size      <= '0;
            cur_burst     <= '0;
            beat_cnt      <= '0;
            wlast_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axi_awready) begin
                        cur_id    <= s_axi_awid;
                        cur_addr  <= s_axi_awaddr;
                        cur_len   <= s_axi_awlen;
                        cur_size  <= s_axi_awsize;
                        cur_burst <= s_axi_awburst;
                        beat_cnt  <= '0;
                        wlast_err <= 1'b0;
                        state     <= ST_WRITE;
                    end else if (s_axi_arready) begin
                        cur_id    <= s_axi_arid;
                        cur_addr  <= s_axi_araddr;
                        cur_len   <= s_axi_arlen;
                        cur_size  <= s_axi_arsize;
                        cur_burst <= s_axi_arburst;
                        beat_cnt  <= '0;
                        state     <= ST_RD_ISSUE;
                    end
                end
                ST_WRITE: begin
                    if (s_axi_wvalid) begin
                        cur_addr <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s_axi_wlast != last_beat) begin
                            wlast_err <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready) begin
                        last_grant_wr <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (s_axi_rready) begin
                        if (last_beat) begin
                            last_grant_wr <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            cur_addr <= next_addr;
                            beat_cnt <= beat_cnt + 8'd1;
                            state    <= ST_RD_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Testbench for axi_sram_ctrl.
// A behavioural SRAM sits behind the controller. Expected memory accesses,
// B responses and R beats are queued when stimulus is issued, and a
// negedge monitor pops and compares them as the DUT produces them.
module tb_axi_sram_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  s_axi_awid;
    logic [15:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  s_axi_arid;
    logic [15:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    axi_sram_ctrl #(
        .ID_WIDTH(8), .ADDR_WIDTH(16), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct {
        bit          wr;
        logic [7:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wlast_at;
        logic [31:0] base;
        logic [3:0]  strb;
        bit          sup;
        logic [1:0]  resp;
    } vec_t;

    mem_exp_t m_q[$];
    b_exp_t   b_q[$];
    r_exp_t   r_q[$];

    logic [31:0] sram    [0:16383];
    logic [31:0] exp_mem [0:16383];

    vec_t vecs [16];

    int checks;
    int failures;
    int cyc;
    int last_r_cyc;
    bit prev_rlast;
    bit spacing_en;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure read beat spacing.
    always @(posedge clk) cyc++;

    // Behavioural single-port SRAM: read data appears the cycle after the
    // access and is held until the next read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) begin
                mem_rdata <= sram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every memory access, B and R handshake against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (m_q.size() == 0) begin
                    check_output("mem_unexpected", 64'(mem_en), 64'(0));
                end else begin
                    mem_exp_t e;
                    e = m_q.pop_front();
                    check_output("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check_output("mem_we", 64'(mem_we), 64'(e.we));
                    if (e.we != 4'h0) check_output("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (b_q.size() == 0) begin
                    check_output("b_unexpected", 64'(s_axi_bvalid), 64'(0));
                end else begin
                    b_exp_t e;
                    e = b_q.pop_front();
                    check_output("bid", 64'(s_axi_bid), 64'(e.id));
                    check_output("bresp", 64'(s_axi_bresp), 64'(e.resp));
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_q.size() == 0) begin
                    check_output("r_unexpected", 64'(s_axi_rvalid), 64'(0));
                end else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    check_output("rid", 64'(s_axi_rid), 64'(e.id));
                    check_output("rdata", 64'(s_axi_rdata), 64'(e.data));
                    check_output("rlast", 64'(s_axi_rlast), 64'(e.last));
                    check_output("rresp", 64'(s_axi_rresp), 64'(e.resp));
                end
                if (spacing_en && !prev_rlast) begin
                    check_output("r_beat_spacing", 64'(cyc - last_r_cyc), 64'(2));
                end
                last_r_cyc = cyc;
                prev_rlast = s_axi_rlast;
            end
        end
    end

    // Reference address sequence, written as base-plus-offset arithmetic.
    function automatic logic [15:0] beat_addr(input logic [15:0] addr, input int k,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input logic [7:0] len);
        int a, bytes, wb, base;
        a = int'(addr);
        bytes = 1 << size;
        case (burst)
            2'b01: beat_addr = (k == 0) ? addr : 16'(((a / bytes) * bytes) + k * bytes);
            2'b10: begin
                wb = bytes * (int'(len) + 1);
                base = (a / wb) * wb;
                beat_addr = 16'(base + ((a - base) + k * bytes) % wb);
            end
            default: beat_addr = addr;
        endcase
    endfunction

    task automatic push_write_exp(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst,
                                  input logic [31:0] base, input logic [3:0] strb,
                                  input bit sup, input logic [1:0] resp);
        for (int k = 0; k <= int'(len); k++) begin
            logic [15:0] a;
            mem_exp_t e;
            a = beat_addr(addr, k, size, burst, len);
            e.addr = a[15:2];
            e.we = sup ? 4'h0 : strb;
            e.wdata = base + 32'(k);
            m_q.push_back(e);
            for (int b = 0; b < 4; b++) begin
                if (e.we[b]) exp_mem[e.addr][8*b +: 8] = e.wdata[8*b +: 8];
            end
        end
        b_q.push_back('{id: id, resp: resp});
    endtask

    task automatic push_read_exp(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input bit sup, input logic [1:0] resp);
        for (int k = 0; k <= int'(len); k++) begin
            logic [15:0] a;
            r_exp_t r;
            a = beat_addr(addr, k, size, burst, len);
            m_q.push_back('{addr: a[15:2], we: 4'h0, wdata: 32'h0});
            r.id = id;
            r.data = sup ? 32'h0 : exp_mem[a[15:2]];
            r.last = (k == int'(len));
            r.resp = resp;
            r_q.push_back(r);
        end
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_axi_awready) done = 1;
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        if (!done) check_output("aw_timeout", 64'(0), 64'(1));
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_axi_arready) done = 1;
            @(posedge clk); #1;
        end
        s_axi_arvalid = 1'b0;
        if (!done) check_output("ar_timeout", 64'(0), 64'(1));
    endtask

    task automatic w_send(input int len, input int wlast_at, input logic [31:0] base, input logic [3:0] strb);
        for (int k = 0; k <= len; k++) begin
            bit done;
            done = 0;
            s_axi_wdata = base + 32'(k);
            s_axi_wstrb = strb;
            s_axi_wlast = (k == wlast_at);
            s_axi_wvalid = 1'b1;
            for (int i = 0; i < 50 && !done; i++) begin
                @(negedge clk);
                if (s_axi_wready) done = 1;
                @(posedge clk); #1;
            end
            if (!done) check_output("w_timeout", 64'(0), 64'(1));
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (m_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0) done = 1;
        end
        if (!done) begin
            check_output("drain_timeout", 64'(m_q.size() + b_q.size() + r_q.size()), 64'(0));
            m_q.delete(); b_q.delete(); r_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.wr) begin
            push_write_exp(v.id, v.addr, v.len, v.size, v.burst, v.base, v.strb, v.sup, v.resp);
            aw_send(v.id, v.addr, v.len, v.size, v.burst);
            w_send(int'(v.len), v.wlast_at, v.base, v.strb);
        end else begin
            push_read_exp(v.id, v.addr, v.len, v.size, v.burst, v.sup, v.resp);
            ar_send(v.id, v.addr, v.len, v.size, v.burst);
        end
        wait_drain();
    endtask

    // Global safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        bit found;
        checks = 0; failures = 0; cyc = 0; last_r_cyc = 0;
        prev_rlast = 1'b1; spacing_en = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            sram[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
        rst = 1'b1;
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0;
        s_axi_awburst = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
        s_axi_bready = 1'b1;
        s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
        s_axi_arburst = 0; s_axi_arvalid = 0;
        s_axi_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_output("rst_awready", 64'(s_axi_awready), 64'(0));
        check_output("rst_arready", 64'(s_axi_arready), 64'(0));
        check_output("rst_wready", 64'(s_axi_wready), 64'(0));
        check_output("rst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check_output("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check_output("rst_mem_en", 64'(mem_en), 64'(0));
        check_output("rst_mem_we", 64'(mem_we), 64'(0));
        check_output("rst_bresp", 64'(s_axi_bresp), 64'(0));
        check_output("rst_rresp", 64'(s_axi_rresp), 64'(0));
        check_output("rst_rdata", 64'(s_axi_rdata), 64'(0));
        check_output("rst_bid", 64'(s_axi_bid), 64'(0));
        check_output("rst_rid", 64'(s_axi_rid), 64'(0));
        @(posedge clk); #1;

        // Contention straight out of reset: write first, then read, then write.
        push_write_exp(8'hA1, 16'h0200, 8'd0, 3'd2, 2'b01, 32'h5A5A0001, 4'hF, 1'b0, 2'b00);
        push_read_exp(8'hB1, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00);
        push_write_exp(8'hA2, 16'h0204, 8'd0, 3'd2, 2'b01, 32'h5A5A0002, 4'hF, 1'b0, 2'b00);
        s_axi_arid = 8'hB1; s_axi_araddr = 16'h0200; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        s_axi_awid = 8'hA1; s_axi_awaddr = 16'h0200; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        @(negedge clk);
        check_output("arb_first_awready", 64'(s_axi_awready), 64'(1));
        check_output("arb_first_arready", 64'(s_axi_arready), 64'(0));
        @(posedge clk); #1;
        s_axi_awid = 8'hA2; s_axi_awaddr = 16'h0204;
        w_send(0, 0, 32'h5A5A0001, 4'hF);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (s_axi_awready || s_axi_arready) found = 1;
        end
        check_output("arb_second_arready", 64'(s_axi_arready), 64'(1));
        check_output("arb_second_awready", 64'(s_axi_awready), 64'(0));
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        aw_send(8'hA2, 16'h0204, 8'd0, 3'd2, 2'b01);
        w_send(0, 0, 32'h5A5A0002, 4'hF);
        wait_drain();

        // Burst table: wr, id, addr, len, size, burst, wlast_at, data base, strb, error, resp.
        vecs[0]  = '{1'b1, 8'h11, 16'h0010, 8'd3, 3'd2, 2'b01, 3,   32'h000000A0, 4'hF, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 8'h22, 16'h0010, 8'd3, 3'd2, 2'b01, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 8'h33, 16'h0030, 8'd3, 3'd2, 2'b01, 3,   32'h00000100, 4'hF, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 8'h44, 16'h0038, 8'd3, 3'd2, 2'b10, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        vecs[4]  = '{1'b1, 8'h55, 16'h0080, 8'd1, 3'd2, 2'b10, 1,   32'hDEAD0000, 4'h5, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 8'h56, 16'h0080, 8'd1, 3'd2, 2'b01, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 8'h57, 16'h0040, 8'd3, 3'd3, 2'b01, 3,   32'h12340000, 4'hF, 1'b1, 2'b10};
        vecs[7]  = '{1'b1, 8'h58, 16'h0060, 8'd3, 3'd2, 2'b11, 3,   32'h56780000, 4'hF, 1'b1, 2'b10};
        vecs[8]  = '{1'b1, 8'h59, 16'h0070, 8'd3, 3'd2, 2'b01, 1,   32'h70700000, 4'hF, 1'b0, 2'b10};
        vecs[9]  = '{1'b1, 8'h5A, 16'h0090, 8'd2, 3'd2, 2'b01, 255, 32'h90900000, 4'hF, 1'b0, 2'b10};
        vecs[10] = '{1'b0, 8'h5B, 16'h0040, 8'd1, 3'd3, 2'b01, 0,   32'h0,        4'h0, 1'b1, 2'b10};
        vecs[11] = '{1'b0, 8'h5C, 16'h0010, 8'd0, 3'd2, 2'b10, 0,   32'h0,        4'h0, 1'b1, 2'b10};
        vecs[12] = '{1'b0, 8'h5D, 16'h0014, 8'd2, 3'd2, 2'b00, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        vecs[13] = '{1'b0, 8'h5E, 16'h0070, 8'd3, 3'd2, 2'b01, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        vecs[14] = '{1'b1, 8'h5F, 16'hFFF8, 8'd3, 3'd2, 2'b01, 3,   32'hFFF80000, 4'hF, 1'b0, 2'b00};
        vecs[15] = '{1'b0, 8'h60, 16'h0090, 8'd2, 3'd2, 2'b01, 0,   32'h0,        4'h0, 1'b0, 2'b00};
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Back-pressure on R in the middle of a burst.
        spacing_en = 1'b0;
        push_read_exp(8'h66, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00);
        ar_send(8'h66, 16'h0010, 8'd3, 3'd2, 2'b01);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) found = 1;
        end
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) found = 1;
        end
        for (int i = 0; i < 5; i++) begin
            check_output("stall_rvalid", 64'(s_axi_rvalid), 64'(1));
            check_output("stall_rdata", 64'(s_axi_rdata), 64'(32'hA1));
            check_output("stall_rlast", 64'(s_axi_rlast), 64'(0));
            check_output("stall_mem_en", 64'(mem_en), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axi_rready = 1'b1;
        wait_drain();
        spacing_en = 1'b1;

        // Reset in the middle of a write burst; only the first two beats land.
        push_write_exp(8'h77, 16'h0300, 8'd3, 3'd2, 2'b01, 32'hC0C00000, 4'hF, 1'b0, 2'b00);
        aw_send(8'h77, 16'h0300, 8'd3, 3'd2, 2'b01);
        w_send(1, 255, 32'hC0C00000, 4'hF);
        rst = 1'b1;
        #1;
        check_output("midrst_wready", 64'(s_axi_wready), 64'(0));
        check_output("midrst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check_output("midrst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check_output("midrst_mem_en", 64'(mem_en), 64'(0));
        check_output("midrst_awready", 64'(s_axi_awready), 64'(0));
        m_q.delete(); b_q.delete(); r_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_read_exp(8'h78, 16'h0300, 8'd1, 3'd2, 2'b01, 1'b0, 2'b00);
        ar_send(8'h78, 16'h0300, 8'd1, 3'd2, 2'b01);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
